// File: rtl/execute_muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer for the Execute stage (shift-add multiply, restoring divide).
// The divider datapath and DIV state are built only when MULDIV_DIV_EN is defined.
module execute_muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_StartE,
  input  logic [1:0]            i_MulDivOpE,
  input  logic [DATA_WIDTH-1:0] i_OperAE,
  input  logic [DATA_WIDTH-1:0] i_OperBE,
  input  logic                  i_FlushE,
  output logic                  o_BusyE,
  output logic                  o_DoneE,
  output logic                  o_DivErrE,
  output logic [DATA_WIDTH-1:0] o_HI,
  output logic [DATA_WIDTH-1:0] o_LO
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic            diverr_q, diverr_d;
  logic            busy_q, busy_d;

  logic            idle_like_s, start_ok_s, is_signed_s, is_div_s;
  logic [W-1:0]    mag_a_s, mag_b_s;
  logic [W:0]      mul_sum_s;
  logic [W2-1:0]   mul_next_s, prod_s;
`ifdef MULDIV_DIV_EN
  logic            remneg_q, remneg_d;
  logic [W:0]      div_trial_s, div_diff_s;
  logic            div_ge_s;
  logic [W2-1:0]   div_next_s;
  logic [W-1:0]    quo_s, rem_s;
`endif

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    if (sgn && v[W-1]) begin
      return ~v + W'(1);
    end else begin
      return v;
    end
  endfunction

  assign idle_like_s = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok_s  = idle_like_s && i_StartE && !i_FlushE;
  assign is_signed_s = ~i_MulDivOpE[0];
  assign is_div_s    = i_MulDivOpE[1];
  assign mag_a_s     = magnitude(i_OperAE, is_signed_s);
  assign mag_b_s     = magnitude(i_OperBE, is_signed_s);

  // Multiply: acc holds {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum_s  = {1'b0, acc_q[W2-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
  assign mul_next_s = {mul_sum_s, acc_q[W-1:1]};
  assign prod_s     = neg_q ? (~mul_next_s + W2'(1)) : mul_next_s;

`ifdef MULDIV_DIV_EN
  // Divide: acc holds {partial remainder, dividend bits}; quotient bits shift in at the bottom.
  assign div_trial_s = {acc_q[W2-1:W], acc_q[W-1]};
  assign div_ge_s    = div_trial_s >= {1'b0, opnd_q};
  assign div_diff_s  = div_trial_s - {1'b0, opnd_q};
  assign div_next_s  = {(div_ge_s ? div_diff_s[W-1:0] : div_trial_s[W-1:0]), acc_q[W-2:0], div_ge_s};
  assign quo_s       = neg_q ? (~div_next_s[W-1:0] + W'(1)) : div_next_s[W-1:0];
  assign rem_s       = remneg_q ? (~div_next_s[W2-1:W] + W'(1)) : div_next_s[W2-1:W];
`endif

  assign o_BusyE   = busy_q || (idle_like_s && i_StartE);
  assign o_DoneE   = done_q;
  assign o_DivErrE = diverr_q;
  assign o_HI      = hi_q;
  assign o_LO      = lo_q;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    diverr_d = 1'b0;
    busy_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    remneg_d = remneg_q;
`endif
    if (i_FlushE) begin
      state_d = S_IDLE;
      cnt_d   = CW'(0);
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok_s && is_div_s) begin
`ifdef MULDIV_DIV_EN
            if (i_OperBE == {W{1'b0}}) begin
              state_d  = S_DONE;
              hi_d     = i_OperAE;
              lo_d     = {W{1'b1}};
              done_d   = 1'b1;
              diverr_d = 1'b1;
            end else begin
              state_d  = S_DIV;
              cnt_d    = CW'(0);
              busy_d   = 1'b1;
              acc_d    = {{W{1'b0}}, mag_a_s};
              opnd_d   = mag_b_s;
              neg_d    = is_signed_s && (i_OperAE[W-1] ^ i_OperBE[W-1]);
              remneg_d = is_signed_s && i_OperAE[W-1];
            end
`else
            state_d  = S_DONE;
            done_d   = 1'b1;
            diverr_d = 1'b1;
`endif
          end else if (start_ok_s) begin
            state_d = S_MUL;
            cnt_d   = CW'(0);
            busy_d  = 1'b1;
            acc_d   = {{W{1'b0}}, mag_b_s};
            opnd_d  = mag_a_s;
            neg_d   = is_signed_s && (i_OperAE[W-1] ^ i_OperBE[W-1]);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          acc_d = mul_next_s;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            cnt_d   = CW'(0);
            done_d  = 1'b1;
            hi_d    = prod_s[W2-1:W];
            lo_d    = prod_s[W-1:0];
          end else begin
            cnt_d  = cnt_q + CW'(1);
            busy_d = 1'b1;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          acc_d = div_next_s;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            cnt_d   = CW'(0);
            done_d  = 1'b1;
            hi_d    = rem_s;
            lo_d    = quo_s;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            busy_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CW'(0);
      hi_q     <= {W{1'b0}};
      lo_q     <= {W{1'b0}};
      acc_q    <= {W2{1'b0}};
      opnd_q   <= {W{1'b0}};
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      diverr_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      remneg_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      diverr_q <= diverr_d;
      busy_q   <= busy_d;
`ifdef MULDIV_DIV_EN
      remneg_q <= remneg_d;
`endif
    end
  end

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// Self-checking bench for execute_muldiv_sequencer: arithmetic reference model plus directed literal checks.
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_execute_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam int DIVCYC = 33;
`else
  localparam int DIVCYC = 1;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic          i_StartE;
  logic [1:0]    i_MulDivOpE;
  logic [W-1:0]  i_OperAE;
  logic [W-1:0]  i_OperBE;
  logic          i_FlushE;
  logic          o_BusyE;
  logic          o_DoneE;
  logic          o_DivErrE;
  logic [W-1:0]  o_HI;
  logic [W-1:0]  o_LO;

  int checks = 0;
  int errors = 0;

  execute_muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_StartE    (i_StartE),
    .i_MulDivOpE (i_MulDivOpE),
    .i_OperAE    (i_OperAE),
    .i_OperBE    (i_OperBE),
    .i_FlushE    (i_FlushE),
    .o_BusyE     (o_BusyE),
    .o_DoneE     (o_DoneE),
    .o_DivErrE   (o_DivErrE),
    .o_HI        (o_HI),
    .o_LO        (o_LO)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation and its latency in cycles after the start cycle.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic err, output int lat);
    logic [63:0] p;
    longint sa, sb, sq, sr;
    hi = cur_hi; lo = cur_lo; err = 1'b0; lat = W;
    case (op)
      2'b00: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = sa * sb; hi = p[63:32]; lo = p[31:0];
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; err = 1'b1; lat = 0;
        end else if (op == 2'b10) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          sq = sa / sb; sr = sa % sb;
          lo = sq[31:0]; hi = sr[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
`else
        err = 1'b1; lat = 0;
`endif
      end
    endcase
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  // Model + compare: check outputs mid-cycle, then advance the model for the coming edge.
  initial begin : model_cmp
    logic [31:0] rh, rl;
    logic        re;
    int          lat;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        m_left = 0; m_done = 1'b0; m_err = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
      end
      chk1("busy", o_BusyE, (m_left > 0) || i_StartE);
      chk1("done", o_DoneE, m_done);
      if (m_done) chk1("diverr", o_DivErrE, m_err);
      chk("hi", o_HI, m_hi);
      chk("lo", o_LO, m_lo);
      if (i_rst_n) begin
        if (i_FlushE) begin
          m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
          m_left--; m_done = 1'b0;
          if (m_left == 0) begin
            m_done = 1'b1; m_err = 1'b0; m_hi = p_hi; m_lo = p_lo;
          end
        end else if (i_StartE) begin
          ref_op(i_MulDivOpE, i_OperAE, i_OperBE, m_hi, m_lo, rh, rl, re, lat);
          if (lat == 0) begin
            m_done = 1'b1; m_err = re; m_hi = rh; m_lo = rl;
          end else begin
            m_left = lat; m_done = 1'b0; p_hi = rh; p_lo = rl;
          end
        end else begin
          m_done = 1'b0;
        end
      end
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output logic b0);
    @(posedge i_clk); #1;
    i_StartE = 1'b1; i_MulDivOpE = op; i_OperAE = a; i_OperBE = b;
    @(negedge i_clk);
    b0 = o_BusyE;
  endtask

  task automatic wait_done(output int dc, output int bc);
    dc = -1; bc = 0;
    for (int c = 1; c < 100; c++) begin
      @(posedge i_clk); #1;
      i_StartE = 1'b0;
      @(negedge i_clk);
      if (o_BusyE) bc++;
      if (o_DoneE) begin
        dc = c;
        break;
      end
    end
  endtask

  logic [1:0]  t_op  [7] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10};
  logic [31:0] t_a   [7] = '{32'h8000_0000, 32'd12345, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                             32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF8};
  logic [31:0] t_b   [7] = '{32'h8000_0000, 32'd678, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
  int          t_cyc [7] = '{33, 33, 33, 33, DIVCYC, DIVCYC, DIVCYC};

  initial begin : stim
    int   dc, bc, dones;
    logic b0;
    i_rst_n = 1'b0; i_StartE = 1'b0; i_MulDivOpE = 2'b00;
    i_OperAE = 32'd0; i_OperBE = 32'd0; i_FlushE = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk1("rst_busy", o_BusyE, 1'b0);
    chk1("rst_done", o_DoneE, 1'b0);
    chk("rst_hi", o_HI, 32'd0);
    chk("rst_lo", o_LO, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // MULTU all-ones squared: busy cycles 0..32, done in cycle 33
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, b0);
    wait_done(dc, bc);
    chk("multu_done_cyc", dc, 32'd33);
    chk("multu_busy_cycles", 32'(b0) + bc, 32'd33);
    chk("multu_hi", o_HI, 32'hFFFF_FFFE);
    chk("multu_lo", o_LO, 32'h0000_0001);

    // MULT -3 x 7 with a back-to-back start in its DONE cycle
    launch(2'b00, 32'hFFFF_FFFD, 32'd7, b0);
    repeat (33) begin
      @(posedge i_clk); #1;
      i_StartE = 1'b0;
    end
    i_StartE = 1'b1; i_MulDivOpE = 2'b01; i_OperAE = 32'd10; i_OperBE = 32'd20;
    @(negedge i_clk);
    chk1("mult_done", o_DoneE, 1'b1);
    chk1("b2b_busy", o_BusyE, 1'b1);
    chk("mult_hi", o_HI, 32'hFFFF_FFFF);
    chk("mult_lo", o_LO, 32'hFFFF_FFEB);
    wait_done(dc, bc);
    chk("b2b_done_cyc", dc, 32'd33);
    chk("b2b_hi", o_HI, 32'd0);
    chk("b2b_lo", o_LO, 32'd200);

`ifdef MULDIV_DIV_EN
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, b0);
    wait_done(dc, bc);
    chk("div_neg_cyc", dc, 32'd33);
    chk1("div_neg_err", o_DivErrE, 1'b0);
    chk("div_neg_lo", o_LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", o_HI, 32'hFFFF_FFFF);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, b0);
    wait_done(dc, bc);
    chk("div_ovf_lo", o_LO, 32'h8000_0000);
    chk("div_ovf_hi", o_HI, 32'd0);
    launch(2'b11, 32'd100, 32'd0, b0);
    wait_done(dc, bc);
    chk("div0_cyc", dc, 32'd1);
    chk1("div0_err", o_DivErrE, 1'b1);
    chk("div0_hi", o_HI, 32'h0000_0064);
    chk("div0_lo", o_LO, 32'hFFFF_FFFF);
`else
    launch(2'b11, 32'd100, 32'd5, b0);
    wait_done(dc, bc);
    chk("nodiv_cyc", dc, 32'd1);
    chk1("nodiv_err", o_DivErrE, 1'b1);
    chk("nodiv_hi", o_HI, 32'd0);
    chk("nodiv_lo", o_LO, 32'd200);
`endif

    for (int i = 0; i < 7; i++) begin
      launch(t_op[i], t_a[i], t_b[i], b0);
      wait_done(dc, bc);
      chk("table_done_cyc", dc, 32'(t_cyc[i]));
    end

    // Known HI/LO before flush and reset tests
    launch(2'b01, 32'hFFFF_FFFF, 32'd3, b0);
    wait_done(dc, bc);
    chk("pre_hi", o_HI, 32'h0000_0002);
    chk("pre_lo", o_LO, 32'hFFFF_FFFD);

    launch(2'b00, 32'd5, 32'd6, b0);
    repeat (10) begin
      @(posedge i_clk); #1;
      i_StartE = 1'b0;
    end
    i_FlushE = 1'b1;
    @(posedge i_clk); #1;
    i_FlushE = 1'b0;
    @(negedge i_clk);
    chk1("flush_busy", o_BusyE, 1'b0);
    chk1("flush_done", o_DoneE, 1'b0);
    chk("flush_hi", o_HI, 32'h0000_0002);
    chk("flush_lo", o_LO, 32'hFFFF_FFFD);
    dones = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_DoneE) dones++;
    end
    chk("flush_no_done", dones, 32'd0);

    // Reset in the middle of a long operation
    launch(2'b10, 32'd1000, 32'd7, b0);
    repeat (5) begin
      @(posedge i_clk); #1;
      i_StartE = 1'b0;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    chk1("mid_rst_busy", o_BusyE, 1'b0);
    chk1("mid_rst_done", o_DoneE, 1'b0);
    chk1("mid_rst_err", o_DivErrE, 1'b0);
    chk("mid_rst_hi", o_HI, 32'd0);
    chk("mid_rst_lo", o_LO, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_DoneE) dones++;
    end
    chk("rst_no_done", dones, 32'd0);

    @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_sequencer.md
EXECUTE_MULDIV_SEQUENCER -- requirements
Module: execute_muldiv_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand width and the HI/LO register width.
REQ-002 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_StartE  input  1  SHALL request a multiply/divide for the instruction currently in Execute.
REQ-005 i_MulDivOpE  input  2  SHALL select the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 i_OperAE  input  DATA_WIDTH  SHALL carry the forwarded rs operand (multiplicand/dividend).
REQ-007 i_OperBE  input  DATA_WIDTH  SHALL carry the forwarded rt operand (multiplier/divisor).
REQ-008 i_FlushE  input  1  SHALL abort any operation in progress.
REQ-009 o_BusyE  output  1  SHALL be the stall request to the hazard unit.
REQ-010 o_DoneE  output  1  SHALL pulse for one cycle when HI/LO have been updated or an error completes.
REQ-011 o_DivErrE  output  1  SHALL flag a divide error, valid only while o_DoneE=1.
REQ-012 o_HI, o_LO  output  DATA_WIDTH each  SHALL present the architectural HI/LO registers.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 A start is accepted in IDLE or DONE when i_StartE=1 and i_FlushE=0; operands and op are latched at that edge (cycle 0); i_StartE in MUL/DIV SHALL be ignored.
REQ-015 On an accepted MULT/MULTU the FSM SHALL go to MUL and perform DATA_WIDTH shift-add iterations, one per cycle, using a counter 0..DATA_WIDTH-1.
REQ-016 On an accepted DIV/DIVU with a nonzero divisor the FSM SHALL go to DIV and perform DATA_WIDTH restoring-division iterations, one per cycle.
REQ-017 The last iteration SHALL transition to DONE and write HI/LO on the same edge, so o_DoneE is high in cycle DATA_WIDTH+1.
REQ-018 DONE SHALL last one cycle, then go to IDLE unless a new start is accepted.
REQ-019 o_BusyE SHALL be combinational: 1 in MUL/DIV, and 1 in IDLE/DONE when i_StartE=1; otherwise 0.
REQ-020 Signed ops SHALL compute on magnitudes. The product is negated if the operand signs differ; the quotient likewise. The remainder takes the dividend sign.
REQ-021 Multiply results: HI = upper half, LO = lower half of the 2*DATA_WIDTH product. Divide results: LO = quotient, HI = remainder.
REQ-022 DIV of the most-negative value by -1 SHALL yield LO = most-negative value and HI = 0.
REQ-023 Divide by zero SHALL go directly IDLE/DONE->DONE and set HI = dividend, LO = all ones and o_DivErrE = 1.
REQ-024 i_FlushE=1 in any state SHALL force IDLE at the next edge, with no o_DoneE and HI/LO unchanged; flush wins over a simultaneous start.

Reset
REQ-025 While i_rst_n=0: state = IDLE, counter = 0, HI = LO = 0, and o_DoneE, o_DivErrE and the registered busy state = 0, immediately and independent of i_clk.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no o_DoneE SHALL follow reset release.

Configuration
REQ-027 With macro MULDIV_DIV_EN defined, the DIV state, divider datapath and REQ-016, REQ-022 and REQ-023 SHALL be compiled in.
REQ-028 Without MULDIV_DIV_EN, DIV/DIVU SHALL go directly to DONE with HI/LO unchanged and o_DivErrE = 1; no divider logic SHALL be synthesized.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_BusyE high in cycles 0..32, o_DoneE in cycle 33, HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-030 MULT -3 x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; back-to-back start in the DONE cycle is accepted and completes 33 cycles later.
REQ-031 DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-032 DIVU 100 / 0 -> o_DoneE and o_DivErrE in cycle 1, HI = 0x00000064, LO = 0xFFFFFFFF.
REQ-033 i_FlushE in cycle 10 of a MULT -> IDLE in cycle 11, o_BusyE = 0, no o_DoneE, HI/LO retain prior values; reset mid-DIV -> all outputs 0 immediately.
REQ-034 Build without MULDIV_DIV_EN, DIVU 100 / 5 -> o_DoneE and o_DivErrE in cycle 1, HI/LO unchanged.
